reram_xbar_arbiter: RTL and testbench
=====================================

Name: reram_xbar_arbiter

Overview:
Round-robin arbiter that shares one ReRAM crossbar compute port (DAC drive in, ADC result out) between NUM_REQ reram_controller instances. It allows one outstanding transaction at a time. It holds xbar_enable for the whole transaction and routes the 12-bit result back to the requester that issued it. A watchdog aborts any transaction whose xbar_valid never arrives. It sits between the controllers and the crossbar/ADC wrapper.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 10, crossbar row/tile address width
DAC_W, 10, DAC drive value width
DATA_W, 12, ADC result width
TIMEOUT, 64, max cycles in WAIT before abort (>=16)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
req_dac  in  NUM_REQ*DAC_W  packed DAC values, same packing
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot response pulse
rsp_data  out  DATA_W  result, shared by all requesters, qualified by rsp_valid
rsp_err  out  1  response is a timeout abort
xbar_enable  out  1  crossbar compute enable
xbar_addr  out  ADDR_W  latched address
xbar_dac  out  DAC_W  latched DAC value
xbar_data  in  DATA_W  ADC result
xbar_valid  in  1  result strobe
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_REQ)  current/last granted index
timeout_cnt  out  8  saturating count of aborts

Behaviour:
- Reset (async): all outputs 0; rr_ptr=0; state=IDLE; timeout_cnt=0. A reset mid-transaction drops xbar_enable immediately, and no response is issued.
- States: IDLE, WAIT, RESP, GAP.
- IDLE:
  - If any req_valid, pick the first set bit searching from rr_ptr upward with wrap.
  - Pulse req_ready[g] for this cycle. A handshake occurs on req_valid & req_ready in the same cycle.
  - Latch addr/dac of g into xbar_addr/xbar_dac; grant_id<=g; wait_cnt<=0; go WAIT.
  - With no requests, stay in IDLE.
- WAIT:
  - xbar_enable=1 with the latched values held constant.
  - wait_cnt increments each cycle.
  - If xbar_valid: capture xbar_data, go RESP.
  - Else if wait_cnt==TIMEOUT-1: go RESP with the abort flag set and data forced to 0; timeout_cnt+=1, saturating at 255.
  - xbar_valid outside WAIT is ignored.
- RESP (1 cycle):
  - xbar_enable=0; rsp_valid[grant_id]=1; rsp_data=captured value; rsp_err=abort flag.
  - rr_ptr<=(grant_id+1) mod NUM_REQ; go GAP.
- GAP (1 cycle): xbar_enable=0, so the crossbar latency counter re-arms. Go IDLE.
- Latency:
  - Accept cycle T; xbar_enable high from T+1.
  - xbar_valid at cycle V gives rsp_valid at V+1.
  - Next grant no earlier than V+3.
- Fairness: a requester holding req_valid is granted within NUM_REQ transactions.
- Requester deasserting req_valid before it receives req_ready: no transaction is recorded for it.
- xbar_valid arriving in the same cycle that wait_cnt reaches TIMEOUT-1: valid wins, and no abort occurs.
- Requesters must not present a new request until their rsp_valid; the arbiter does not check this.

Decomposition:
- Shared package reram_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2, GAP=2'd3);
  - default widths ADDR_W/DAC_W/DATA_W, shared with reram_controller;
  - the TIMEOUT default.
- One sub-module: rr_priority_pick. It is combinational; it takes req vector and rr_ptr and returns a one-hot grant plus an index. It is separately testable.

Test Plan:
1. Single requester 0, addr=5, dac=100; mock xbar answers (dac*4)%4096 after 11 enabled cycles:
   - req_ready[0] pulse;
   - xbar_enable held 11 cycles;
   - rsp_valid[0] with data=400, rsp_err=0;
   - busy drops 2 cycles after RESP.
2. All 4 requesters held valid with dac=10,20,30,40:
   - grants in order 0,1,2,3,0;
   - each response returns to the matching rsp_valid bit with data 40,80,120,160.
3. Requester 2 finishes, then requesters 1 and 3 request: 3 is granted first (rr_ptr=3), then 1.
4. Crossbar never asserts xbar_valid, TIMEOUT=64:
   - abort after exactly 64 WAIT cycles;
   - rsp_valid with rsp_err=1 and data=0;
   - timeout_cnt=1;
   - the next request proceeds normally.
5. rst_n asserted during WAIT:
   - xbar_enable, busy and all rsp_valid go 0 asynchronously;
   - after release, the first grant goes to requester 0.
6. xbar_valid asserted in the same cycle as timeout expiry: normal response, rsp_err=0, timeout_cnt unchanged.

Source files
------------

// File: rtl/reram_pkg.sv
// reram_pkg: definitions shared by the ReRAM crossbar arbiter and reram_controller.
//   state_t          - arbiter FSM state encoding
//   RERAM_*_W        - default address / DAC / ADC result widths
//   RERAM_TIMEOUT    - default watchdog limit in WAIT cycles
//   sat_inc8()       - saturating 8-bit increment used for event counters
package reram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int RERAM_ADDR_W  = 10;
  localparam int RERAM_DAC_W   = 10;
  localparam int RERAM_DATA_W  = 12;
  localparam int RERAM_TIMEOUT = 64;

  // Increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker.
// Searches i_req starting at index i_ptr and wrapping upward; the first set
// bit found wins.
//   i_req   - request vector
//   i_ptr   - search start index (must be < NUM_REQ)
//   o_grant - one-hot grant (all zero when no request)
//   o_idx   - index of the granted requester (0 when no request)
//   o_any   - at least one request present
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IW-1:0] w_pos [NUM_REQ];
  logic [IW-1:0] w_idx;
  logic          w_any;

  // Walk the requesters in rotated order; only the first hit updates the index.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos[k] = IW'((int'(i_ptr) + k) % NUM_REQ);
      w_idx    = (i_req[w_pos[k]] && !w_any) ? w_pos[k] : w_idx;
      w_any    = w_any | i_req[w_pos[k]];
    end
  end

  assign o_idx   = w_idx;
  assign o_any   = w_any;
  assign o_grant = w_any ? (ONE << w_idx) : {NUM_REQ{1'b0}};

endmodule

// File: rtl/reram_xbar_arbiter.sv
// reram_xbar_arbiter: shares one ReRAM crossbar compute port between NUM_REQ
// controllers, one transaction at a time, with round-robin fairness and a
// watchdog that aborts transactions whose result strobe never arrives.
//   req_valid/req_addr/req_dac - packed per-requester requests (slice i = requester i)
//   req_ready                  - one-hot accept, combinational in IDLE
//   rsp_valid/rsp_data/rsp_err - one-hot response pulse, shared data, abort flag
//   xbar_enable/addr/dac       - crossbar drive, held for the whole WAIT phase
//   xbar_data/xbar_valid       - ADC result and strobe (ignored outside WAIT)
//   busy                       - transaction in progress (any state but IDLE)
//   grant_id                   - current/last granted requester
//   timeout_cnt                - saturating number of watchdog aborts
module reram_xbar_arbiter
  import reram_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = RERAM_ADDR_W,
  parameter int DAC_W   = RERAM_DAC_W,
  parameter int DATA_W  = RERAM_DATA_W,
  parameter int TIMEOUT = RERAM_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DAC_W-1:0]    req_dac,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        xbar_enable,
  output logic [ADDR_W-1:0]           xbar_addr,
  output logic [DAC_W-1:0]            xbar_dac,
  input  logic [DATA_W-1:0]           xbar_data,
  input  logic                        xbar_valid,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [7:0]                  timeout_cnt
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0]     WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [IW-1:0]      LAST_ID   = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE       = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next_state;
  logic [IW-1:0]        r_rr_ptr;
  logic [WCW-1:0]       r_wait_cnt;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_data;
  logic                 r_rsp_err;
  logic                 r_xbar_enable;
  logic [ADDR_W-1:0]    r_xbar_addr;
  logic [DAC_W-1:0]     r_xbar_dac;
  logic                 r_busy;
  logic [IW-1:0]        r_grant_id;
  logic [7:0]           r_timeout_cnt;

  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_pick_any;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic                 w_wait_last;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_onehot),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Next-state decode and the combinational accept pulse.
  always_comb begin
    w_next_state = r_state;
    w_req_ready  = '0;
    w_wait_last  = (r_wait_cnt == WAIT_LAST);
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_next_state = ST_WAIT;
          w_req_ready  = w_pick_onehot;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A result strobe on the last watchdog cycle still counts as success.
        if (xbar_valid) begin
          w_next_state = ST_RESP;
        end else if (w_wait_last) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: w_next_state = ST_GAP;
      ST_GAP:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, datapath latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_wait_cnt    <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_xbar_enable <= 1'b0;
      r_xbar_addr   <= '0;
      r_xbar_dac    <= '0;
      r_busy        <= 1'b0;
      r_grant_id    <= '0;
      r_timeout_cnt <= 8'd0;
    end else begin
      r_state       <= w_next_state;
      r_xbar_enable <= (w_next_state == ST_WAIT);
      r_busy        <= (w_next_state != ST_IDLE);
      r_rsp_valid   <= '0;
      r_rsp_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_xbar_addr <= req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
            r_xbar_dac  <= req_dac[int'(w_pick_idx)*DAC_W +: DAC_W];
            r_grant_id  <= w_pick_idx;
            r_wait_cnt  <= '0;
          end
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WCW'(1);
          if (xbar_valid) begin
            r_rsp_valid <= ONE << r_grant_id;
            r_rsp_data  <= xbar_data;
            r_rsp_err   <= 1'b0;
          end else if (w_wait_last) begin
            r_rsp_valid   <= ONE << r_grant_id;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b1;
            r_timeout_cnt <= sat_inc8(r_timeout_cnt);
          end
        end
        ST_RESP: begin
          r_rr_ptr <= (r_grant_id == LAST_ID) ? '0 : (r_grant_id + IW'(1));
        end
        ST_GAP: begin
          r_rr_ptr <= r_rr_ptr;
        end
        default: begin
          r_rr_ptr <= '0;
        end
      endcase
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign xbar_enable = r_xbar_enable;
  assign xbar_addr   = r_xbar_addr;
  assign xbar_dac    = r_xbar_dac;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_reram_xbar_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for reram_xbar_arbiter: expected grants/responses are queued
// as stimulus is issued; a monitor pops and compares on req_ready/rsp_valid.
module tb_reram_xbar_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 10;
  localparam int RW = 12;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_dac;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [RW-1:0]   rsp_data;
  logic            rsp_err;
  logic            xbar_enable;
  logic [AW-1:0]   xbar_addr;
  logic [DW-1:0]   xbar_dac;
  logic [RW-1:0]   xbar_data;
  logic            xbar_valid;
  logic            busy;
  logic [1:0]      grant_id;
  logic [7:0]      timeout_cnt;

  reram_xbar_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DAC_W(DW), .DATA_W(RW), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_dac(req_dac),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .xbar_enable(xbar_enable), .xbar_addr(xbar_addr), .xbar_dac(xbar_dac),
    .xbar_data(xbar_data), .xbar_valid(xbar_valid), .busy(busy), .grant_id(grant_id),
    .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  mask;
    logic [11:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_rsp[$];
  int   exp_grant[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mock_on;
  int   mock_lat;
  int   en_cnt;
  int   mon_g;
  rsp_t mon_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rsp(input logic [3:0] m, input logic [11:0] d, input logic e);
    rsp_t r;
    r.mask = m; r.data = d; r.err = e;
    exp_rsp.push_back(r);
  endtask

  task automatic set_req(input int i, input int addr, input int dac);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = AW'(addr);
    req_dac[i*DW +: DW]  = DW'(dac);
  endtask

  // Hold the requests in mask until each one is accepted, then drop it after the edge.
  task automatic serve(input logic [3:0] mask);
    logic [3:0] pend;
    logic [3:0] hit;
    int n;
    pend = mask; n = 0;
    #1;
    while (pend != 4'd0 && n < 300) begin
      hit = req_ready & pend;
      if (hit != 4'd0) begin
        @(posedge clk); #1;
        req_valid = req_valid & ~hit;
        pend = pend & ~hit;
      end
      @(negedge clk); #2;
      n++;
    end
    if (pend != 4'd0) chk("serve_timeout", 32'(pend), 32'd0);
  endtask

  task automatic count_enable(output int c);
    c = 0;
    while (xbar_enable && c < 300) begin
      c++;
      @(negedge clk); #2;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while ((busy || exp_rsp.size() != 0) && n < 400);
    if (busy || exp_rsp.size() != 0) chk(name, 32'(exp_rsp.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Mock crossbar: strobe (dac*4)%4096 in the mock_lat-th enabled cycle.
  initial begin
    xbar_valid = 1'b0;
    xbar_data  = '0;
    en_cnt     = 0;
    forever begin
      @(negedge clk);
      if (xbar_enable) en_cnt++;
      else en_cnt = 0;
      if (mock_on && xbar_enable && en_cnt == mock_lat) begin
        xbar_valid = 1'b1;
        xbar_data  = RW'((int'(xbar_dac) * 4) % 4096);
      end else begin
        xbar_valid = 1'b0;
        xbar_data  = '0;
      end
    end
  end

  // Monitor: compare every accept and every response against the scoreboard.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (rst_n) begin
        if (req_ready != 4'd0) begin
          if (exp_grant.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'd0);
          else begin
            mon_g = exp_grant.pop_front();
            chk("grant_onehot", 32'(req_ready), 32'd1 << mon_g);
          end
        end
        if (rsp_valid != 4'd0) begin
          if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          else begin
            mon_r = exp_rsp.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(mon_r.mask));
            chk("rsp_data",  32'(rsp_data),  32'(mon_r.data));
            chk("rsp_err",   32'(rsp_err),   32'(mon_r.err));
          end
        end
      end
    end
  end

  initial begin
    int c;
    int n;
    int g;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_dac = '0;
    mock_on = 1'b1; mock_lat = 11;
    repeat (2) @(negedge clk); #2;
    chk("rst_enable", 32'(xbar_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
    chk("rst_xbar_addr", 32'(xbar_addr), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk); #2;
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Test 1: single requester, 11-cycle crossbar latency.
    @(negedge clk); #1;
    set_req(0, 5, 100);
    exp_grant.push_back(0); push_rsp(4'b0001, 12'd400, 1'b0);
    serve(4'b0001);
    chk("t1_xbar_addr", 32'(xbar_addr), 32'd5);
    chk("t1_xbar_dac", 32'(xbar_dac), 32'd100);
    count_enable(c);
    chk("t1_enable_cycles", 32'(c), 32'd11);
    n = 0;
    while (busy && n < 10) begin @(negedge clk); #2; n++; end
    chk("t1_busy_drop", 32'(n), 32'd2);
    wait_idle("t1_idle");

    // Test 2: all four held, fresh pointer.
    do_reset();
    mock_lat = 3;
    @(negedge clk); #1;
    set_req(0, 0, 10); set_req(1, 1, 20); set_req(2, 2, 30); set_req(3, 3, 40);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    push_rsp(4'b0001, 12'd40, 1'b0);  push_rsp(4'b0010, 12'd80, 1'b0);
    push_rsp(4'b0100, 12'd120, 1'b0); push_rsp(4'b1000, 12'd160, 1'b0);
    push_rsp(4'b0001, 12'd40, 1'b0);
    g = 0; n = 0;
    #1;
    while (g < 5 && n < 400) begin
      if (req_ready != 4'd0) begin
        g++;
        if (g == 5) begin @(posedge clk); #1; req_valid = '0; end
      end
      @(negedge clk); #2;
      n++;
    end
    chk("t2_grant_count", 32'(g), 32'd5);
    wait_idle("t2_idle");

    // Test 3: requester 2 then {1,3}; pointer at 3 favours requester 3.
    @(negedge clk); #1;
    set_req(2, 2, 50);
    exp_grant.push_back(2); push_rsp(4'b0100, 12'd200, 1'b0);
    serve(4'b0100);
    wait_idle("t3a_idle");
    @(negedge clk); #1;
    set_req(1, 1, 7); set_req(3, 3, 9);
    exp_grant.push_back(3); exp_grant.push_back(1);
    push_rsp(4'b1000, 12'd36, 1'b0); push_rsp(4'b0010, 12'd28, 1'b0);
    serve(4'b1010);
    wait_idle("t3b_idle");

    // Test 4: crossbar silent -> watchdog abort, then a normal transaction.
    mock_on = 1'b0;
    @(negedge clk); #1;
    set_req(0, 1, 50);
    exp_grant.push_back(0); push_rsp(4'b0001, 12'd0, 1'b1);
    serve(4'b0001);
    count_enable(c);
    chk("t4_wait_cycles", 32'(c), 32'd64);
    chk("t4_timeout_cnt", 32'(timeout_cnt), 32'd1);
    wait_idle("t4a_idle");
    mock_on = 1'b1; mock_lat = 5;
    @(negedge clk); #1;
    set_req(1, 4, 25);
    exp_grant.push_back(1); push_rsp(4'b0010, 12'd100, 1'b0);
    serve(4'b0010);
    wait_idle("t4b_idle");

    // Test 6: strobe on the final watchdog cycle wins.
    mock_lat = 64;
    @(negedge clk); #1;
    set_req(2, 6, 11);
    exp_grant.push_back(2); push_rsp(4'b0100, 12'd44, 1'b0);
    serve(4'b0100);
    count_enable(c);
    chk("t6_wait_cycles", 32'(c), 32'd64);
    wait_idle("t6_idle");
    chk("t6_timeout_cnt", 32'(timeout_cnt), 32'd1);

    // Test 5: reset during WAIT, then pointer restarts at 0.
    mock_on = 1'b0;
    @(negedge clk); #1;
    set_req(1, 7, 3);
    exp_grant.push_back(1);
    serve(4'b0010);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_enable_async", 32'(xbar_enable), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_rsp_async", 32'(rsp_valid), 32'd0);
    chk("t5_timeout_cnt", 32'(timeout_cnt), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    mock_on = 1'b1; mock_lat = 2;
    @(negedge clk); #1;
    set_req(0, 8, 1); set_req(3, 9, 2);
    exp_grant.push_back(0); exp_grant.push_back(3);
    push_rsp(4'b0001, 12'd4, 1'b0); push_rsp(4'b1000, 12'd8, 1'b0);
    serve(4'b1001);
    wait_idle("t5_idle");

    chk("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
